branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 128 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//
// Resolves one branch or jump per cycle and keeps a table of 2-bit
// saturating counters (the PHT) that the front end reads to predict
// conditional branches.
//
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   valid_in          - a branch or jump is presented this cycle
//   pc                - address of the sequential next instruction
//   rs                - register operand (jump base and condition source)
//   imm               - sign-extended displacement
//   cond              - 00 eqz, 01 nez, 10 ltz, 11 gez (ignored for jumps)
//   jump              - unconditional transfer
//   reg_based         - target base is rs when 1, pc when 0
//   pred_taken_in     - front-end prediction for the presented branch
//   stall, flush      - hold / squash the resolve stage
//   query_pc          - address looked up in the PHT
//   pred_taken        - combinational prediction for query_pc
//   valid_out, taken, mispredict, target, next_pc - registered results

module branch_resolve_unit #(
    parameter int WIDTH     = 16,
    parameter int PHT_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] imm,
    input  logic [1:0]       cond,
    input  logic             jump,
    input  logic             reg_based,
    input  logic             pred_taken_in,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] query_pc,
    output logic             pred_taken,
    output logic             valid_out,
    output logic             taken,
    output logic             mispredict,
    output logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] next_pc
);

    localparam int IDX_W = $clog2(PHT_DEPTH);

    logic [1:0]       pht [PHT_DEPTH];

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] target_c;
    logic             cond_true;
    logic             taken_c;

    logic             pred_q;
    logic             jump_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] query_idx;
    logic             pht_update;
    logic             unused_query;

    // Instructions are halfword aligned, so bit 0 never selects an entry.
    assign query_idx    = query_pc[IDX_W:1];
    assign unused_query = ^{query_pc[WIDTH-1:IDX_W+1], query_pc[0]};

    // No bypass: a same-cycle update is seen only after the edge.
    assign pred_taken = pht[query_idx][1];

    assign mispredict = valid_out & (taken != pred_q);

    // A resolved conditional branch trains the table only on the edge it
    // leaves the stage, so holding it under stall never counts twice.
    assign pht_update = valid_out & ~stall & ~flush & ~jump_q;

    // Target adder (wraps modulo 2^WIDTH) and condition evaluation.
    always_comb begin
        base      = reg_based ? rs : pc;
        target_c  = base + imm;
        cond_true = 1'b0;
        case (cond)
            2'b00:   cond_true = (rs == '0);
            2'b01:   cond_true = (rs != '0);
            2'b10:   cond_true = rs[WIDTH-1];
            default: cond_true = ~rs[WIDTH-1];
        endcase
        taken_c = jump | cond_true;
    end

    // Resolve stage registers: flush only clears valid, stall holds all.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            taken     <= 1'b0;
            target    <= '0;
            next_pc   <= '0;
            pred_q    <= 1'b0;
            jump_q    <= 1'b0;
            idx_q     <= '0;
        end else if (flush) begin
            valid_out <= 1'b0;
        end else if (!stall) begin
            valid_out <= valid_in;
            taken     <= taken_c;
            target    <= target_c;
            next_pc   <= taken_c ? target_c : pc;
            pred_q    <= pred_taken_in;
            jump_q    <= jump;
            idx_q     <= pc[IDX_W:1];
        end
    end

    // Pattern history table: saturating 2-bit counters, reset weakly not-taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (pht_update) begin
            if (taken && pht[idx_q] != 2'b11) begin
                pht[idx_q] <= pht[idx_q] + 2'd1;
            end else if (!taken && pht[idx_q] != 2'b00) begin
                pht[idx_q] <= pht[idx_q] - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit
//
// Self-checking bench: a table of directed vectors with fixed expected
// results, hand-written sequences for predictor saturation, stall/flush and
// reset, then randomized traffic compared against a behavioural model.

module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [15:0] pc, rs, imm, query_pc;
    logic [1:0]  cond;
    logic        jump, reg_based, pred_taken_in, stall, flush;
    logic        pred_taken, valid_out, taken, mispredict;
    logic [15:0] target, next_pc;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int          pht_m [16];
    bit          m_valid, m_taken, m_pred, m_jump;
    logic [15:0] m_target, m_next;
    int          m_idx;

    typedef struct {
        logic [15:0] pc, rs, imm;
        logic [1:0]  cond;
        logic        jump, reg_based, pred;
        logic        e_taken;
        logic [15:0] e_target, e_next;
        logic        e_mis;
    } vec_t;

    vec_t vecs [7];

    branch_resolve_unit #(.WIDTH(16), .PHT_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .pc(pc), .rs(rs), .imm(imm),
        .cond(cond), .jump(jump), .reg_based(reg_based),
        .pred_taken_in(pred_taken_in), .stall(stall), .flush(flush),
        .query_pc(query_pc), .pred_taken(pred_taken), .valid_out(valid_out),
        .taken(taken), .mispredict(mispredict), .target(target), .next_pc(next_pc)
    );

    always #5 clk = ~clk;

    // Advance the reference model by one clock edge using the current inputs.
    task automatic modelEdge();
        logic [31:0] sum;
        bit          c;
        if (rst) begin
            foreach (pht_m[i]) pht_m[i] = 1;
            m_valid = 0; m_taken = 0; m_pred = 0; m_jump = 0;
            m_target = 0; m_next = 0; m_idx = 0;
            return;
        end
        if (m_valid && !stall && !flush && !m_jump) begin
            if (m_taken) pht_m[m_idx] = (pht_m[m_idx] == 3) ? 3 : pht_m[m_idx] + 1;
            else         pht_m[m_idx] = (pht_m[m_idx] == 0) ? 0 : pht_m[m_idx] - 1;
        end
        if (flush) begin
            m_valid = 0;
        end else if (!stall) begin
            sum = {16'h0, (reg_based ? rs : pc)} + {16'h0, imm};
            case (cond)
                2'b00: c = (rs == 0);
                2'b01: c = (rs != 0);
                2'b10: c = ($signed(rs) < 0);
                default: c = ($signed(rs) >= 0);
            endcase
            m_valid  = valid_in;
            m_taken  = jump || c;
            m_target = sum[15:0];
            m_next   = m_taken ? m_target : pc;
            m_pred   = pred_taken_in;
            m_jump   = jump;
            m_idx    = (pc / 2) % 16;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("valid_out", valid_out, m_valid);
        checkOutput("taken", taken, m_taken);
        checkOutput("target", target, m_target);
        checkOutput("next_pc", next_pc, m_next);
        checkOutput("mispredict", mispredict, m_valid && (m_taken != m_pred));
        checkOutput("pred_taken", pred_taken, pht_m[(query_pc / 2) % 16] >= 2);
    endtask

    // One clock edge: model follows the edge, DUT sampled 1 time unit later.
    task automatic applyStimulus();
        @(posedge clk);
        modelEdge();
        #1;
        checkModel();
    endtask

    task automatic idleInputs();
        rst = 0; valid_in = 0; pc = 0; rs = 0; imm = 0; cond = 0; jump = 0;
        reg_based = 0; pred_taken_in = 0; stall = 0; flush = 0; query_pc = 0;
    endtask

    task automatic doReset();
        rst = 1;
        applyStimulus();
        rst = 0;
    endtask

    task automatic presentBranch(input logic [15:0] p, input logic [15:0] r,
                                 input logic [1:0] c);
        valid_in = 1; pc = p; rs = r; imm = 16'h0010; cond = c;
        jump = 0; reg_based = 0; pred_taken_in = 0;
    endtask

    initial begin
        vecs[0] = '{16'h0010, 16'h0000, 16'h0008, 2'b00, 0, 0, 0, 1, 16'h0018, 16'h0018, 1};
        vecs[1] = '{16'h0020, 16'h0005, 16'h0010, 2'b10, 0, 0, 0, 0, 16'h0030, 16'h0020, 0};
        vecs[2] = '{16'h0040, 16'hFFFE, 16'h0004, 2'b00, 1, 1, 1, 1, 16'h0002, 16'h0002, 0};
        vecs[3] = '{16'h0100, 16'h0003, 16'hFFF0, 2'b01, 0, 0, 1, 1, 16'h00F0, 16'h00F0, 0};
        vecs[4] = '{16'h0200, 16'h8000, 16'h0020, 2'b11, 0, 0, 1, 0, 16'h0220, 16'h0200, 1};
        vecs[5] = '{16'h0300, 16'h8001, 16'h0100, 2'b10, 0, 0, 0, 1, 16'h0400, 16'h0400, 1};
        vecs[6] = '{16'h0050, 16'h0000, 16'h0010, 2'b01, 1, 0, 0, 1, 16'h0060, 16'h0060, 1};

        idleInputs();
        rst = 1;
        applyStimulus();
        applyStimulus();
        rst = 0;
        checkOutput("reset valid_out", valid_out, 0);
        checkOutput("reset target", target, 0);

        // Directed vectors with fixed expectations.
        for (int i = 0; i < 7; i++) begin
            valid_in = 1; pc = vecs[i].pc; rs = vecs[i].rs; imm = vecs[i].imm;
            cond = vecs[i].cond; jump = vecs[i].jump; reg_based = vecs[i].reg_based;
            pred_taken_in = vecs[i].pred;
            applyStimulus();
            checkOutput($sformatf("vec%0d valid", i), valid_out, 1);
            checkOutput($sformatf("vec%0d taken", i), taken, vecs[i].e_taken);
            checkOutput($sformatf("vec%0d target", i), target, vecs[i].e_target);
            checkOutput($sformatf("vec%0d next_pc", i), next_pc, vecs[i].e_next);
            checkOutput($sformatf("vec%0d mispredict", i), mispredict, vecs[i].e_mis);
        end

        // Saturation: three taken then one not-taken branch at pc 0x0004.
        idleInputs();
        doReset();
        query_pc = 16'h0004;
        checkOutput("post-reset pred", pred_taken, 0);
        presentBranch(16'h0004, 16'h0000, 2'b00);
        applyStimulus();
        checkOutput("sat pred after load1", pred_taken, 0);
        applyStimulus();
        checkOutput("sat pred 01->10", pred_taken, 1);
        applyStimulus();
        checkOutput("sat pred 10->11", pred_taken, 1);
        rs = 16'h0001;
        applyStimulus();
        checkOutput("sat pred 11->11", pred_taken, 1);
        valid_in = 0;
        applyStimulus();
        checkOutput("sat pred 11->10", pred_taken, 1);
        applyStimulus();
        checkOutput("sat pred hold 10", pred_taken, 1);

        // Stall three cycles, then flush together with stall.
        idleInputs();
        doReset();
        query_pc = 16'h0004;
        presentBranch(16'h0004, 16'h0000, 2'b00);
        applyStimulus();
        valid_in = 0; stall = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("stall valid hold", valid_out, 1);
            checkOutput("stall target hold", target, 16'h0014);
            checkOutput("stall pred unchanged", pred_taken, 0);
        end
        flush = 1;
        applyStimulus();
        checkOutput("flush valid", valid_out, 0);
        checkOutput("flush target hold", target, 16'h0014);
        flush = 0; stall = 0;
        applyStimulus();
        checkOutput("flush counter 01", pred_taken, 0);

        // Reset while an entry is in flight.
        idleInputs();
        presentBranch(16'h0006, 16'h0000, 2'b00);
        applyStimulus();
        checkOutput("pre-reset valid", valid_out, 1);
        rst = 1;
        applyStimulus();
        rst = 0; valid_in = 0;
        checkOutput("mid reset valid", valid_out, 0);
        checkOutput("mid reset taken", taken, 0);
        checkOutput("mid reset next_pc", next_pc, 0);
        for (int i = 0; i < 16; i++) begin
            query_pc = 16'(i * 2);
            #1;
            checkOutput($sformatf("reset pht entry %0d", i), pred_taken, 0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst           = ($urandom_range(0, 99) < 2);
            valid_in      = $urandom_range(0, 1);
            pc            = 16'($urandom_range(0, 31) * 2);
            rs            = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            imm           = 16'($urandom);
            cond          = 2'($urandom_range(0, 3));
            jump          = ($urandom_range(0, 5) == 0);
            reg_based     = $urandom_range(0, 1);
            pred_taken_in = $urandom_range(0, 1);
            stall         = ($urandom_range(0, 4) == 0);
            flush         = ($urandom_range(0, 9) == 0);
            query_pc      = 16'($urandom);
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
